inpcont: RTL and testbench
==========================

# inpcont

Input-port controller for one router input channel: the requesting end of the output-port arbitration interface. It buffers incoming flits, looks up the output port for each head flit in the external node table, and raises `req`/`port` toward the five output-port mux controllers. It holds the request until the packet's tail flit has left, and streams flits downstream only while it holds a grant.

## Interface
- `PORTID`, 0, index of this input port; selects this port's bit in each output's grant vector.
- `FLITW`, 64, flit width; bits [FLITW-1:FLITW-2] are the type field, bits [FLITW-3:FLITW-10] are the destination node id.
- `DEPTH`, 4, FIFO depth in flits; must be a power of two, minimum 2.

Ports:
- `clk`  in  1  clock.
- `rst_`  in  1  reset, asynchronous, active-low.
- `in_data`  in  FLITW  flit from the upstream link.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a flit.
- `rt_dst`  out  8  destination id of the FIFO-head flit, driven to the node table.
- `rt_port`  in  3  output port returned by the node table (0-4), combinational.
- `rt_mc`  in  1  node table marks the destination as multicast.
- `port`  out  3  requested output port.
- `req`  out  1  request to output `port`.
- `multab`  out  2  multicast status to the arbiters; bit1 = multicast request, bit0 = packet active.
- `grt_in`  in  5  bit k = grant from output k's arbiter for this `PORTID`.
- `out_data`  out  FLITW  flit to the crossbar.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the flit.
- `err_cnt`  out  8  saturating count of dropped orphan flits.

## Operation
- Flit types: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail).
- FIFO: registered, DEPTH entries. Read and write pointers are log2(DEPTH)+1 bits, so the extra MSB distinguishes full from empty.
  - Push when `in_valid & in_ready`.
  - `in_ready = !full`. A full FIFO never accepts a push, even if a pop happens in the same cycle.
- FSM states:
  - **IDLE**:
    - If the FIFO is non-empty and the head flit is type 01 or 11: latch `rt_port` into `port` and `rt_mc` into the multicast flag, then go to REQ.
    - If the head flit is type 00 or 10 (orphan): pop and discard it, increment `err_cnt` (saturating at 255), stay in IDLE.
  - **REQ**: `req=1`, `multab[0]=1`. When `grt_in[port]=1`, go to XFER.
  - **XFER**:
    - `req` stays 1 so the arbiter keeps its hold.
    - `out_valid = !empty & grt_in[port]`; `out_data` = FIFO head.
    - A pop occurs when `out_valid & out_ready`.
    - Popping a type 10 or 11 flit goes to IDLE; `req` and `multab` clear in the next cycle.
- If `rt_port > 4`: treat as a route miss. Discard the whole packet (pop through its tail without requesting) and increment `err_cnt` once per packet.
- `rt_dst` always reflects the FIFO-head destination field, regardless of state.

## Timing
- Reset values:
  - `req`, `port`, `multab`, `out_valid`, `err_cnt`: 0.
  - FIFO: empty, so `in_ready` = 1.
  - FSM: IDLE.
- Head flit pushed at cycle 0:
  - Cycle 1: flit at FIFO head; route latched.
  - Cycle 2: `req` high.
- Grant seen at cycle n → XFER at n+1, first `out_valid` at n+1. This matches the arbiter's registered select.
- Sustained throughput: 1 flit/cycle while the FIFO is non-empty, the grant is held and `out_ready`=1.
- Grant lost during XFER: `out_valid` drops the same cycle; no pop; stay in XFER with `req` held.
- Empty FIFO during XFER: `out_valid`=0; wait for the next flit.
- Pointers wrap modulo DEPTH. A simultaneous push and pop keeps the occupancy unchanged.
- `rst_` asserted mid-packet: everything returns immediately to reset values, and FIFO contents are lost.

## Configuration
- `INPCONT_MULTICAST_EN` defined:
  - `multab[1]` = latched `rt_mc` during REQ and XFER, so arbiters give this request priority.
- `INPCONT_MULTICAST_EN` undefined:
  - `rt_mc` is ignored and `multab[1]` is tied to 0.
  - `multab[0]` behaves identically in both builds.

## Test plan
- Reset, then push single flit {11, dst 5}, `rt_port`=3, `grt_in`=5'b01000 when `req` rises, `out_ready`=1 → `req`=1/`port`=3 at cycle 2; one `out_valid` pulse; back to IDLE, `req`=0.
- Four-flit packet 01,00,00,10; `grt_in[2]` deasserted for 3 cycles mid-packet → `out_valid` low for those cycles, flit order preserved, `req` held throughout, released after the tail.
- `in_valid` held high with `out_ready`=0 → `in_ready`=0 after DEPTH pushes; set `out_ready`=1 → FIFO drains, pointers wrap, data intact.
- Body flit arriving in IDLE → dropped, `err_cnt`=1; 300 orphan flits → `err_cnt`=255.
- `rt_mc`=1 on a head flit → `multab`=2'b11 with the macro defined, 2'b01 with it undefined.
- `rst_` pulsed low during XFER → `req`, `out_valid` = 0 immediately; next packet routes normally.

Source files
------------

// File: rtl/inpcont.sv
// inpcont: input-port controller for one router input channel.
// Buffers incoming flits in a small FIFO, routes each head flit through the
// external node table, requests the chosen output port and streams the packet
// to the crossbar while the grant is held. Orphan flits and packets whose
// route is out of range are discarded and counted in err_cnt.
// Optional feature: define INPCONT_MULTICAST_EN to drive the latched
// multicast flag onto multab[1]; otherwise multab[1] is tied low.
module inpcont #(
  parameter int PORTID = 0,
  parameter int FLITW  = 64,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [FLITW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       rt_dst,
  input  logic [2:0]       rt_port,
  input  logic             rt_mc,
  output logic [2:0]       port,
  output logic             req,
  output logic [1:0]       multab,
  input  logic [4:0]       grt_in,
  output logic [FLITW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       err_cnt
);

  localparam int AW = $clog2(DEPTH);

  // Parameter sanity: a router has five outputs, and the pointer scheme needs a power-of-two depth.
  generate
    if (PORTID < 0 || PORTID > 4) begin : g_bad_portid
      $error("inpcont: PORTID must be in 0..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("inpcont: DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DROP = 2'd3
  } state_t;

  logic [FLITW-1:0] mem_q [DEPTH];
  logic [AW:0]      rptr_q, rptr_d, wptr_q, wptr_d;
  state_t           state_q, state_d;
  logic [2:0]       port_q, port_d;
  logic             mc_q, mc_d;
  logic             req_q, req_d;
  logic [1:0]       multab_q, multab_d;
  logic [7:0]       err_q, err_d;

  logic             empty_s, full_s, push_s, pop_s;
  logic [FLITW-1:0] head_s;
  logic [1:0]       head_type_s;
  logic             grant_s, out_valid_s, active_s, rt_mc_s;
  logic [7:0]       err_inc_s;

`ifdef INPCONT_MULTICAST_EN
  assign rt_mc_s = rt_mc;
`else
  logic unused_rt_mc_s;
  assign rt_mc_s        = 1'b0;
  assign unused_rt_mc_s = rt_mc;
`endif

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty_s     = (rptr_q == wptr_q);
  assign full_s      = (rptr_q[AW] != wptr_q[AW]) && (rptr_q[AW-1:0] == wptr_q[AW-1:0]);
  assign push_s      = in_valid && !full_s;
  assign head_s      = mem_q[rptr_q[AW-1:0]];
  assign head_type_s = head_s[FLITW-1:FLITW-2];
  assign grant_s     = grt_in[port_q];
  assign out_valid_s = (state_q == S_XFER) && !empty_s && grant_s;
  assign err_inc_s   = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);

  assign in_ready  = !full_s;
  assign rt_dst    = head_s[FLITW-3:FLITW-10];
  assign port      = port_q;
  assign req       = req_q;
  assign multab    = multab_q;
  assign out_data  = head_s;
  assign out_valid = out_valid_s;
  assign err_cnt   = err_q;

  // Next-state logic: routing, request hold, packet transfer and discard paths.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    mc_d    = mc_q;
    err_d   = err_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (empty_s) begin
          state_d = S_IDLE;
        end else if (!head_type_s[0]) begin
          // body or tail flit with no packet open: drop it
          pop_s = 1'b1;
          err_d = err_inc_s;
        end else if (rt_port <= 3'd4) begin
          port_d  = rt_port;
          mc_d    = rt_mc_s;
          state_d = S_REQ;
        end else begin
          // route miss: count once, then discard through the tail
          pop_s = 1'b1;
          err_d = err_inc_s;
          if (head_type_s[1]) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_REQ: begin
        if (grant_s) begin
          state_d = S_XFER;
        end else begin
          state_d = S_REQ;
        end
      end
      S_XFER: begin
        if (out_valid_s && out_ready) begin
          pop_s = 1'b1;
          if (head_type_s[1]) begin
            state_d = S_IDLE;
            mc_d    = 1'b0;
          end else begin
            state_d = S_XFER;
          end
        end else begin
          state_d = S_XFER;
        end
      end
      S_DROP: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (head_type_s[1]) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DROP;
          end
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    active_s = (state_d == S_REQ) || (state_d == S_XFER);
    req_d    = active_s;
    multab_d = {mc_d & active_s, active_s};
    wptr_d   = push_s ? (wptr_q + (AW+1)'(1)) : wptr_q;
    rptr_d   = pop_s ? (rptr_q + (AW+1)'(1)) : rptr_q;
  end

  // Control and status registers; reset empties the FIFO and drops any open packet.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= S_IDLE;
      port_q   <= 3'd0;
      mc_q     <= 1'b0;
      req_q    <= 1'b0;
      multab_q <= 2'b00;
      err_q    <= 8'd0;
      rptr_q   <= '0;
      wptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      mc_q     <= mc_d;
      req_q    <= req_d;
      multab_q <= multab_d;
      err_q    <= err_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
    end
  end

  // FIFO storage: data only, validity is carried by the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_inpcont.sv
// Testbench for inpcont: directed scenarios plus randomized packet traffic.
// Expected output flits are queued at input acceptance from a packet-level
// model (route table, orphan and route-miss rules) and popped by a monitor.
module tb_inpcont;

  logic        clk;
  logic        rst_;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  rt_dst;
  logic [2:0]  rt_port;
  logic        rt_mc;
  logic [2:0]  port;
  logic        req;
  logic [1:0]  multab;
  logic [4:0]  grt_in;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_cnt;

`ifdef INPCONT_MULTICAST_EN
  localparam logic MC_EN = 1'b1;
`else
  localparam logic MC_EN = 1'b0;
`endif

  int          errors = 0;
  int          checks = 0;
  int          exp_err = 0;
  logic [63:0] exp_q [$];
  logic [2:0]  route_tbl [256];
  logic        mc_tbl [256];
  logic        gnt_ok = 1'b1;
  logic        force_off = 1'b0;
  logic        rand_mode = 1'b0;

  inpcont #(.PORTID(0), .FLITW(64), .DEPTH(4)) dut (
    .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rt_dst(rt_dst), .rt_port(rt_port), .rt_mc(rt_mc),
    .port(port), .req(req), .multab(multab), .grt_in(grt_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // node table and a simple arbiter that grants the requested output
  assign rt_port = route_tbl[rt_dst];
  assign rt_mc   = mc_tbl[rt_dst];
  assign grt_in  = (req && gnt_ok && !force_off) ? (5'b00001 << port) : 5'b00000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [7:0] d);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {t, d, r[53:0]};
  endfunction

  // drive one flit and hold it until accepted; queue it if it should come out
  task automatic send_flit(input logic [63:0] f, input logic exp_out);
    logic ok;
    ok = 1'b0;
    in_data  = f;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send timeout: got in_ready=0 expected 1 within bound");
    end else begin
      if (exp_out) exp_q.push_back(f);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || req !== 1'b0) begin
      errors++;
      $display("FAIL %s drain: got left=%0d req=%0b expected left=0 req=0", name, exp_q.size(), req);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    out_ready = 1'b0;
    force_off = 1'b0;
    gnt_ok    = 1'b1;
    exp_q.delete();
    exp_err = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  // monitor: every accepted output flit must be the next expected one
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_ && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_data unexpected: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %h expected %h", out_data, e);
          end
        end
      end
    end
  end

  // random backpressure and grant loss
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        out_ready = ($urandom_range(0, 3) != 0);
        gnt_ok    = ($urandom_range(0, 4) != 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f [6];
    logic [7:0]  d;
    logic        ok;
    int          len;
    logic [1:0]  t;

    for (int i = 0; i < 256; i++) begin
      route_tbl[i] = 3'(i % 8);
      mc_tbl[i]    = ((i % 4) == 1);
    end
    route_tbl[5] = 3'd3;

    do_reset();
    @(negedge clk);
    chk("reset req", {63'd0, req}, 64'd0);
    chk("reset port", {61'd0, port}, 64'd0);
    chk("reset multab", {62'd0, multab}, 64'd0);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset err_cnt", {56'd0, err_cnt}, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // single flit, dst 5 routes to port 3
    out_ready = 1'b1;
    send_flit(mk(2'b11, 8'd5), 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("d1 req cycle1", {63'd0, req}, 64'd0);
    @(negedge clk);
    chk("d1 req cycle2", {63'd0, req}, 64'd1);
    chk("d1 port cycle2", {61'd0, port}, 64'd3);
    chk("d1 multab", {62'd0, multab}, {62'd0, MC_EN & mc_tbl[5], 1'b1});
    @(negedge clk);
    chk("d1 out_valid cycle3", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("d1 req released", {63'd0, req}, 64'd0);
    chk("d1 multab released", {62'd0, multab}, 64'd0);
    chk("d1 single pulse", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    wait_drain("d1");

    // four-flit packet with grant lost for three cycles
    out_ready = 1'b0;
    f[0] = mk(2'b01, 8'd2);
    f[1] = mk(2'b00, 8'd2);
    f[2] = mk(2'b00, 8'd2);
    f[3] = mk(2'b10, 8'd2);
    for (int k = 0; k < 4; k++) send_flit(f[k], 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("d2 first valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    force_off = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("d2 valid while no grant", {63'd0, out_valid}, 64'd0);
      chk("d2 req held", {63'd0, req}, 64'd1);
    end
    @(posedge clk);
    #1;
    force_off = 1'b0;
    chk("d2 flits pending", 64'(exp_q.size()), 64'd3);
    wait_drain("d2");

    // fill the FIFO with the output stalled, then drain through a wrap
    out_ready = 1'b0;
    f[0] = mk(2'b01, 8'd4);
    for (int k = 1; k < 5; k++) f[k] = mk(2'b00, 8'd4);
    f[5] = mk(2'b10, 8'd4);
    for (int k = 0; k < 4; k++) send_flit(f[k], 1'b1);
    in_data  = f[4];
    in_valid = 1'b1;
    @(negedge clk);
    chk("d3 full in_ready", {63'd0, in_ready}, 64'd0);
    chk("d3 head presented", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_flit(f[4], 1'b1);
    send_flit(f[5], 1'b1);
    in_valid = 1'b0;
    wait_drain("d3");

    // multicast head flit
    force_off = 1'b1;
    send_flit(mk(2'b11, 8'd9), 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !req; i++) @(negedge clk);
    @(negedge clk);
    chk("mc req", {63'd0, req}, 64'd1);
    chk("mc multab", {62'd0, multab}, {62'd0, MC_EN, 1'b1});
    chk("mc port", {61'd0, port}, 64'd1);
    @(posedge clk);
    #1;
    force_off = 1'b0;
    wait_drain("mc");
    chk("directed err_cnt", {56'd0, err_cnt}, 64'd0);

    // randomized traffic: packets, orphans, route misses, stalls
    rand_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 4) == 0) begin
        t = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
        send_flit(mk(t, 8'($urandom_range(0, 255))), 1'b0);
        exp_err++;
      end
      len = $urandom_range(1, 5);
      d   = 8'($urandom_range(0, 15));
      ok  = (route_tbl[d] <= 3'd4);
      if (!ok) exp_err++;
      for (int k = 0; k < len; k++) begin
        t = (len == 1) ? 2'b11 : (k == 0) ? 2'b01 : (k == len - 1) ? 2'b10 : 2'b00;
        send_flit(mk(t, d), ok);
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
    end
    in_valid  = 1'b0;
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    gnt_ok    = 1'b1;
    wait_drain("random");
    chk("random err_cnt", {56'd0, err_cnt}, 64'((exp_err > 255) ? 255 : exp_err));

    // orphans in IDLE and counter saturation
    do_reset();
    out_ready = 1'b1;
    send_flit(mk(2'b00, 8'd1), 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("orphan err_cnt 1", {56'd0, err_cnt}, 64'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 299; k++) send_flit(mk(((k % 2) == 1) ? 2'b10 : 2'b00, 8'(k)), 1'b0);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("orphan err_cnt sat", {56'd0, err_cnt}, 64'd255);
    chk("orphan no req", {63'd0, req}, 64'd0);
    @(posedge clk);
    #1;

    // reset in the middle of a transfer
    out_ready = 1'b0;
    send_flit(mk(2'b01, 8'd2), 1'b1);
    send_flit(mk(2'b00, 8'd2), 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("rst setup valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    #1;
    chk("rst req", {63'd0, req}, 64'd0);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst err_cnt", {56'd0, err_cnt}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_      = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_flit(mk(2'b11, 8'd3), 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post-rst port", {61'd0, port}, 64'd3);
    @(posedge clk);
    #1;
    wait_drain("post-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
